// File: rtl/bitrev_reorder.sv
// rtl/bitrev_reorder.sv - ping-pong frame buffer emitting 2^N-sample frames in bit-reversed or natural order
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   rev_en            readout order for the next frame (1 = bit-reversed), latched at frame start
//   in_valid/in_ready/in_data        natural-order sample input stream
//   out_valid/out_ready/out_data     reordered sample output stream
//   out_idx           memory address (natural index) of out_data, for twiddle addressing
//   out_last          final sample of a frame

module bitrev_reorder #(
   parameter int N = 9,
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rev_en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [N-1:0] out_idx,
   output logic         out_last
);

   localparam logic [N-1:0] CNT_LAST = '1;
   localparam logic [N-1:0] CNT_ONE  = 1;
   localparam int           DEPTH    = 1 << (N + 1);

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_st_t;

   bank_st_t     st_q [2];
   bank_st_t     st_d [2];
   logic [1:0]   mode_q, mode_d;
   logic         wr_bank_q, wr_bank_d;
   logic [N-1:0] wr_cnt_q, wr_cnt_d;
   logic         rd_bank_q, rd_bank_d;
   logic [N-1:0] rd_cnt_q, rd_cnt_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
   logic [N-1:0] out_idx_q, out_idx_d;
   logic         out_last_q, out_last_d;
   logic [W-1:0] out_data_q;

   logic [W-1:0] mem [DEPTH];

   logic         wr_en;
   logic         rd_en;
   logic         can_issue;
   logic [N-1:0] rd_addr;

   function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) begin
         r[i] = a[N-1-i];
      end
      return r;
   endfunction

   always_comb begin
      wr_en     = in_valid && in_ready_q;
      can_issue = (st_q[rd_bank_q] == FULL) || (st_q[rd_bank_q] == DRAINING);
      // A read may issue whenever the output register is free or being emptied this edge.
      rd_en     = can_issue && (!out_valid_q || out_ready);
      rd_addr   = mode_q[rd_bank_q] ? bitrev(rd_cnt_q) : rd_cnt_q;

      st_d        = st_q;
      mode_d      = mode_q;
      wr_bank_d   = wr_bank_q;
      wr_cnt_d    = wr_cnt_q;
      rd_bank_d   = rd_bank_q;
      rd_cnt_d    = rd_cnt_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;

      if (wr_en) begin
         if (st_q[wr_bank_q] == EMPTY) begin
            st_d[wr_bank_q]   = FILLING;
            mode_d[wr_bank_q] = rev_en;
         end
         wr_cnt_d = wr_cnt_q + CNT_ONE;
         if (wr_cnt_q == CNT_LAST) begin
            st_d[wr_bank_q] = FULL;
            wr_bank_d       = ~wr_bank_q;
         end
      end

      if (rd_en) begin
         st_d[rd_bank_q] = DRAINING;
         rd_cnt_d        = rd_cnt_q + CNT_ONE;
         out_valid_d     = 1'b1;
         out_idx_d       = rd_addr;
         out_last_d      = (rd_cnt_q == CNT_LAST);
         // Once the last read is issued the frame's final sample sits in the output
         // register, so the bank memory is free for refill; this keeps back-to-back
         // frames gap-free on the input side.
         if (rd_cnt_q == CNT_LAST) begin
            st_d[rd_bank_q] = EMPTY;
            rd_bank_d       = ~rd_bank_q;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      in_ready_d = (st_d[wr_bank_d] == EMPTY) || (st_d[wr_bank_d] == FILLING);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q[0]     <= EMPTY;
         st_q[1]     <= EMPTY;
         mode_q      <= '0;
         wr_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_bank_q   <= 1'b0;
         rd_cnt_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         st_q        <= st_d;
         mode_q      <= mode_d;
         wr_bank_q   <= wr_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_bank_q   <= rd_bank_d;
         rd_cnt_q    <= rd_cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   // Sample storage: {bank, address}; plain write port, no reset, so it maps to block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wr_bank_q, wr_cnt_q}] <= in_data;
      end
   end

   // Registered read port doubles as the output data register.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q <= '0;
      end else if (rd_en) begin
         out_data_q <= mem[{rd_bank_q, rd_addr}];
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_bitrev_reorder.sv
// tb/tb_bitrev_reorder.sv - self-checking bench for bitrev_reorder at N=3 (directed) and N=9 (random)

module tb_bitrev_reorder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // N=3 instance
   logic        rst0, rev0, iv0, ird0, ov0, ord0, ol0;
   logic [31:0] id0, od0;
   logic [2:0]  oi0;
   // N=9 instance
   logic        rst1, rev1, iv1, ird1, ov1, ord1, ol1;
   logic [31:0] id1, od1;
   logic [8:0]  oi1;

   bitrev_reorder #(.N(3), .W(32)) u_small (
      .clk(clk), .reset(rst0), .rev_en(rev0), .in_valid(iv0), .in_ready(ird0), .in_data(id0),
      .out_valid(ov0), .out_ready(ord0), .out_data(od0), .out_idx(oi0), .out_last(ol0)
   );

   bitrev_reorder #(.N(9), .W(32)) u_big (
      .clk(clk), .reset(rst1), .rev_en(rev1), .in_valid(iv1), .in_ready(ird1), .in_data(id1),
      .out_valid(ov1), .out_ready(ord1), .out_data(od1), .out_idx(oi1), .out_last(ol1)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: collect each frame, then queue its samples in readout order.
   logic [31:0] fb [2][512];
   logic [31:0] ed [2][4096];
   int          ei [2][4096];
   bit          el [2][4096];
   int          fcnt [2];
   int          head [2];
   int          tail [2];
   bit          fmode [2];
   bit          held [2];
   logic [31:0] hd [2];
   logic [9:0]  hi [2];
   logic        hl [2];
   int          nouts [2];
   int          nlast [2];

   logic [31:0] lgd [64];
   int          lgi [64];
   int          lgc [64];
   int          lgn = 0;
   bit          done1 = 0;

   function automatic int brev(input int k, input int nn);
      int r = 0;
      for (int b = 0; b < nn; b++) r = r * 2 + ((k >> b) & 1);
      return r;
   endfunction

   task automatic mon(input int id, input logic rs, input logic iv, input logic ir,
                      input logic [31:0] din, input logic rv, input logic ov, input logic ordy,
                      input logic [31:0] dout, input logic [9:0] oidx, input logic ol);
      int nn, len, h, src;
      nn  = (id == 1) ? 9 : 3;
      len = 1 << nn;
      if (rs) begin
         fcnt[id] = 0; head[id] = 0; tail[id] = 0; held[id] = 0;
         nouts[id] = 0; nlast[id] = 0;
      end else begin
         if (held[id]) begin
            chk(ov === 1'b1, "hold_valid", longint'(ov), 1);
            chk(dout == hd[id] && oidx == hi[id] && ol == hl[id], "hold_stable", dout, hd[id]);
         end
         held[id] = ov && !ordy;
         hd[id] = dout; hi[id] = oidx; hl[id] = ol;
         if (ov && ordy) begin
            chk(head[id] != tail[id], "unexpected_out", dout, 0);
            if (head[id] != tail[id]) begin
               h = head[id] % 4096;
               chk(dout == ed[id][h], "out_data", dout, ed[id][h]);
               chk(int'(oidx) == ei[id][h], "out_idx", oidx, ei[id][h]);
               chk(ol == el[id][h], "out_last", longint'(ol), longint'(el[id][h]));
               head[id]++;
            end
            nouts[id]++;
            if (ol) nlast[id]++;
            if (id == 0 && lgn < 64) begin
               lgd[lgn] = dout; lgi[lgn] = int'(oidx); lgc[lgn] = cyc; lgn++;
            end
         end
         if (iv && ir) begin
            if (fcnt[id] == 0) fmode[id] = rv;
            fb[id][fcnt[id]] = din;
            fcnt[id]++;
            if (fcnt[id] == len) begin
               for (int k = 0; k < len; k++) begin
                  src = fmode[id] ? brev(k, nn) : k;
                  ed[id][tail[id] % 4096] = fb[id][src];
                  ei[id][tail[id] % 4096] = src;
                  el[id][tail[id] % 4096] = (k == len - 1);
                  tail[id]++;
               end
               fcnt[id] = 0;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, rst0, iv0, ird0, id0, rev0, ov0, ord0, od0, {7'b0, oi0}, ol0);
      mon(1, rst1, iv1, ird1, id1, rev1, ov1, ord1, od1, {1'b0, oi1}, ol1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic stream0(input int base, input int n, input int lim, input logic [2:0] pat,
                          input bit jitter, output int sent, output int ticks);
      bit r;
      sent = 0; ticks = 0;
      while (sent < n && ticks < lim) begin
         iv0 = 1'b1;
         id0 = 32'(base + sent);
         if (!jitter || (sent % 8) == 0) rev0 = pat[(sent / 8) % 3];
         else rev0 = 1'($urandom % 2);
         r = ird0;
         tick();
         ticks++;
         if (r) sent++;
      end
      iv0 = 1'b0;
   endtask

   task automatic wait_log(input int n, input int lim);
      int t = 0;
      while (lgn < n && t < lim) begin tick(); t++; end
      chk(lgn >= n, "drain_timeout", lgn, n);
   endtask

   int br8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   // Random traffic on the N=9 instance
   initial begin
      int sent, guard;
      bit r;
      rst1 = 1'b1; iv1 = 1'b0; ord1 = 1'b0; rev1 = 1'b0; id1 = '0;
      repeat (2) tick();
      rst1 = 1'b0;
      sent = 0; guard = 0;
      while (sent < 2048 && guard < 20000) begin
         iv1  = ($urandom % 5) != 0;
         id1  = $urandom;
         rev1 = 1'($urandom % 2);
         ord1 = 1'($urandom % 2);
         r = iv1 && ird1;
         tick();
         guard++;
         if (r) sent++;
      end
      iv1 = 1'b0;
      chk(sent == 2048, "rand_in_count", sent, 2048);
      guard = 0;
      while (nouts[1] < 2048 && guard < 20000) begin
         ord1 = 1'($urandom % 2);
         tick();
         guard++;
      end
      repeat (5) tick();
      chk(nouts[1] == 2048, "rand_out_count", nouts[1], 2048);
      chk(nlast[1] == 4, "rand_last_count", nlast[1], 4);
      chk(head[1] == tail[1], "rand_queue_empty", tail[1] - head[1], 0);
      done1 = 1;
   end

   // Directed tests on the N=3 instance
   initial begin
      int sent, ticks, t;
      rst0 = 1'b1; iv0 = 1'b0; ord0 = 1'b1; rev0 = 1'b1; id0 = '0;
      tick();
      chk(ov0 == 1'b0, "rst_out_valid", ov0, 0);
      chk(ird0 == 1'b0, "rst_in_ready", ird0, 0);
      chk(od0 == 32'd0, "rst_out_data", od0, 0);
      chk(oi0 == 3'd0, "rst_out_idx", oi0, 0);
      chk(ol0 == 1'b0, "rst_out_last", ol0, 0);
      rst0 = 1'b0;
      tick();
      chk(ird0 == 1'b1, "post_rst_in_ready", ird0, 1);

      // Bit-reversed frame 0..7 and first-output latency
      lgn = 0;
      stream0(0, 8, 50, 3'b111, 0, sent, ticks);
      chk(ov0 == 1'b0, "lat_not_yet", ov0, 0);
      tick();
      chk(ov0 == 1'b1, "lat_valid", ov0, 1);
      wait_log(8, 100);
      for (int k = 0; k < 8; k++) begin
         chk(lgd[k] == 32'(br8[k]), "t1_data", lgd[k], br8[k]);
         chk(lgi[k] == br8[k], "t1_idx", lgi[k], br8[k]);
      end
      chk(nlast[0] == 1, "t1_last_once", nlast[0], 1);

      // Natural-order frame 10..17
      lgn = 0;
      stream0(10, 8, 50, 3'b000, 0, sent, ticks);
      wait_log(8, 100);
      for (int k = 0; k < 8; k++) begin
         chk(lgd[k] == 32'(10 + k), "t2_data", lgd[k], 10 + k);
         chk(lgi[k] == k, "t2_idx", lgi[k], k);
      end

      // Three back-to-back frames, rev 1,0,1, rev_en jittered mid-frame
      lgn = 0;
      stream0(0, 24, 100, 3'b101, 1, sent, ticks);
      chk(ticks == 24, "t3_in_no_stall", ticks, 24);
      wait_log(24, 100);
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < 8; k++)
            chk(lgd[f*8+k] == 32'(f*8 + ((f != 1) ? br8[k] : k)), "t3_seq", lgd[f*8+k],
                f*8 + ((f != 1) ? br8[k] : k));
      chk(lgc[23] - lgc[0] == 23, "t3_no_bubble", lgc[23] - lgc[0], 23);

      // Output stalled: only two frames fit
      lgn = 0;
      ord0 = 1'b0;
      stream0(200, 20, 40, 3'b111, 0, sent, ticks);
      chk(sent == 16, "t4_accepted", sent, 16);
      chk(ird0 == 1'b0, "t4_in_ready_low", ird0, 0);
      chk(ov0 == 1'b1 && od0 == 32'd200 && oi0 == 3'd0, "t4_held_out", od0, 200);
      ord0 = 1'b1;
      stream0(216, 8, 100, 3'b111, 0, sent, ticks);
      wait_log(24, 200);
      chk(lgn == 24, "t4_count", lgn, 24);
      chk(lgd[0] == 32'd200, "t4_first", lgd[0], 200);
      chk(lgd[8] == 32'd208, "t4_frame2", lgd[8], 208);
      chk(lgd[16] == 32'd216, "t4_frame3", lgd[16], 216);

      // Reset mid-frame discards the partial frame
      lgn = 0;
      stream0(50, 5, 20, 3'b111, 0, sent, ticks);
      rst0 = 1'b1;
      tick();
      chk(ov0 == 1'b0, "t6_rst_valid", ov0, 0);
      chk(ird0 == 1'b0, "t6_rst_ready", ird0, 0);
      rst0 = 1'b0;
      tick();
      stream0(100, 8, 50, 3'b111, 0, sent, ticks);
      wait_log(8, 100);
      repeat (20) tick();
      chk(lgn == 8, "t6_no_remnants", lgn, 8);
      for (int k = 0; k < 8; k++)
         chk(lgd[k] == 32'(100 + br8[k]), "t6_data", lgd[k], 100 + br8[k]);
      chk(head[0] == tail[0], "small_queue_empty", tail[0] - head[0], 0);

      t = 0;
      while (!done1 && t < 30000) begin tick(); t++; end
      chk(done1, "rand_timeout", longint'(done1), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
